// File: rtl/fp8_pkg.sv
// Shared E5M2 constants, accumulator state encoding and flag bit positions.
package fp8_pkg;

  localparam int FP8_WIDTH     = 8;
  localparam int FP8_EXP_WIDTH = 5;
  localparam int FP8_MAN_WIDTH = 2;

  localparam logic [FP8_WIDTH-1:0] FP8_POS_ZERO = 8'h00;
  localparam logic [FP8_WIDTH-1:0] FP8_POS_INF  = 8'h7C;
  localparam logic [FP8_WIDTH-1:0] FP8_EXP_MASK = 8'h7C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

  // flags vector is {nan, inf, cnt_sat}
  localparam int FP8_NUM_FLAGS = 3;
  localparam int FLAG_NAN      = 2;
  localparam int FLAG_INF      = 1;
  localparam int FLAG_CNT_SAT  = 0;

endpackage

// File: rtl/fp8_accumulator_if.sv
// Term/result bundle between the FP8 adder loop, the accumulator and its consumer.
interface fp8_accumulator_if
  import fp8_pkg::*;
#(
  parameter int WIDTH     = FP8_WIDTH,
  parameter int CNT_WIDTH = 8
);

  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;
  logic [WIDTH-1:0]         sum_in;
  logic [WIDTH-1:0]         acc_fb;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         acc_out;
  logic [CNT_WIDTH-1:0]     count;
  logic [FP8_NUM_FLAGS-1:0] flags;

  modport master (
    output in_valid, in_last, sum_in, out_ready,
    input  in_ready, acc_fb, out_valid, acc_out, count, flags
  );

  modport slave (
    input  in_valid, in_last, sum_in, out_ready,
    output in_ready, acc_fb, out_valid, acc_out, count, flags
  );

endinterface

// File: rtl/fp8_classify.sv
// Combinational minifloat classifier: flags Inf, NaN and signed zero of one operand.
module fp8_classify
  import fp8_pkg::*;
#(
  parameter int WIDTH     = FP8_WIDTH,
  parameter int EXP_WIDTH = FP8_EXP_WIDTH,
  parameter int MAN_WIDTH = FP8_MAN_WIDTH
) (
  input  logic [WIDTH-1:0] op_i,
  output logic             is_inf_o,
  output logic             is_nan_o,
  output logic             is_zero_o
);

  logic [EXP_WIDTH-1:0] exp_fld;
  logic [MAN_WIDTH-1:0] man_fld;
  logic                 exp_ones;
  logic                 man_zero;

  assign exp_fld  = op_i[MAN_WIDTH +: EXP_WIDTH];
  assign man_fld  = op_i[MAN_WIDTH-1:0];
  assign exp_ones = &exp_fld;
  assign man_zero = (man_fld == '0);

  assign is_inf_o  = exp_ones && man_zero;
  assign is_nan_o  = exp_ones && !man_zero;
  assign is_zero_o = (exp_fld == '0) && man_zero;

endmodule

// File: rtl/fp8_accumulator.sv
// Running-sum register closing the loop around a combinational FP8 adder; one term/cycle.
// Optional sticky exception flags are built when FP8_ACC_FLAGS_EN is defined.
module fp8_accumulator
  import fp8_pkg::*;
#(
  parameter int WIDTH     = FP8_WIDTH,
  parameter int EXP_WIDTH = FP8_EXP_WIDTH,
  parameter int MAN_WIDTH = FP8_MAN_WIDTH,
  parameter int CNT_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  fp8_accumulator_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  acc_state_e           state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 out_valid_q;
  logic                 in_ready_q;
  logic                 accept;
  logic                 cnt_full;

`ifdef FP8_ACC_FLAGS_EN
  logic [FP8_NUM_FLAGS-1:0] flags_q, flags_d;
  logic                     cls_inf;
  logic                     cls_nan;
  logic                     cls_zero_unused;

  fp8_classify #(
    .WIDTH     (WIDTH),
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH)
  ) u_classify (
    .op_i      (bus.sum_in),
    .is_inf_o  (cls_inf),
    .is_nan_o  (cls_nan),
    .is_zero_o (cls_zero_unused)
  );
`else
  // Format parameters only feed the classifier; keep them referenced here.
  localparam int unused_fmt_bits = EXP_WIDTH + MAN_WIDTH;
`endif

  assign accept   = bus.in_valid && in_ready_q;
  assign cnt_full = (count_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
`ifdef FP8_ACC_FLAGS_EN
    flags_d = flags_q;
`endif
    if (clear) begin
      state_d = IDLE;
      acc_d   = FP8_POS_ZERO;
      count_d = '0;
`ifdef FP8_ACC_FLAGS_EN
      flags_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            // count_q is zero in IDLE, so the same increment yields 1 there.
            acc_d   = bus.sum_in;
            count_d = cnt_full ? count_q : count_q + CNT_ONE;
            state_d = bus.in_last ? DONE : ACCUM;
`ifdef FP8_ACC_FLAGS_EN
            flags_d[FLAG_NAN]     = flags_q[FLAG_NAN] | cls_nan;
            flags_d[FLAG_INF]     = flags_q[FLAG_INF] | cls_inf;
            flags_d[FLAG_CNT_SAT] = flags_q[FLAG_CNT_SAT] | cnt_full;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
            acc_d   = FP8_POS_ZERO;
            count_d = '0;
`ifdef FP8_ACC_FLAGS_EN
            flags_d = '0;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = FP8_POS_ZERO;
          count_d = '0;
        end
      endcase
    end
  end

  // Handshake outputs are registered from the next state so no input reaches them combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= FP8_POS_ZERO;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= (state_d == DONE);
      in_ready_q  <= (state_d != DONE);
    end
  end

`ifdef FP8_ACC_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.flags = flags_q;
`else
  assign bus.flags = '0;
`endif

  assign bus.acc_fb    = acc_q;
  assign bus.acc_out   = acc_q;
  assign bus.count     = count_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_fp8_accumulator.sv
// Bench for fp8_accumulator: directed vector table, async reset and saturation sequences, random run vs model.
module tb_fp8_accumulator;

`ifdef FP8_ACC_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic clear;

  int checks;
  int failures;

  fp8_accumulator_if #(.WIDTH(8), .CNT_WIDTH(8)) bus_a ();
  fp8_accumulator_if #(.WIDTH(8), .CNT_WIDTH(2)) bus_b ();

  fp8_accumulator #(.WIDTH(8), .EXP_WIDTH(5), .MAN_WIDTH(2), .CNT_WIDTH(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus_a)
  );

  fp8_accumulator #(.WIDTH(8), .EXP_WIDTH(5), .MAN_WIDTH(2), .CNT_WIDTH(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit       l;
    bit [7:0] s;
    bit       ordy;
    bit       clr;
    bit [7:0] e_acc;
    int       e_cnt;
    bit       e_ovld;
    bit       e_irdy;
    bit [2:0] e_flags;
  } vec_t;

  vec_t vecs[$];

  // Reference model state for DUT A
  bit [7:0] m_acc;
  int       m_cnt;
  bit       m_done;
  bit [2:0] m_flags;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit [2:0] eff(input bit [2:0] f);
    return FLAGS_ON ? f : 3'b000;
  endfunction

  function automatic vec_t mk(input bit v, input bit l, input bit [7:0] s, input bit ordy, input bit clr,
                              input bit [7:0] ea, input int ec, input bit eo, input bit ei, input bit [2:0] ef);
    vec_t t;
    t.v = v; t.l = l; t.s = s; t.ordy = ordy; t.clr = clr;
    t.e_acc = ea; t.e_cnt = ec; t.e_ovld = eo; t.e_irdy = ei; t.e_flags = ef;
    return t;
  endfunction

  task automatic drive_a(input bit v, input bit l, input bit [7:0] s, input bit ordy, input bit clr);
    bus_a.in_valid  = v;
    bus_a.in_last   = l;
    bus_a.sum_in    = s;
    bus_a.out_ready = ordy;
    clear           = clr;
  endtask

  task automatic check_a(input string tag, input bit [7:0] ea, input int ec, input bit eo, input bit ei, input bit [2:0] ef);
    chk({tag, " acc_fb"},    bus_a.acc_fb, ea);
    chk({tag, " acc_out"},   bus_a.acc_out, ea);
    chk({tag, " count"},     bus_a.count, ec);
    chk({tag, " out_valid"}, bus_a.out_valid, eo);
    chk({tag, " in_ready"},  bus_a.in_ready, ei);
    chk({tag, " flags"},     bus_a.flags, eff(ef));
  endtask

  // Abstract behaviour: a stream either collecting terms or presenting a result.
  task automatic model_clock(input bit v, input bit l, input bit [7:0] s, input bit ordy, input bit clr);
    int e;
    int m;
    if (clr) begin
      m_acc = 8'h00; m_cnt = 0; m_done = 0; m_flags = 3'b000;
    end else if (!m_done) begin
      if (v) begin
        e = (s / 4) % 32;
        m = s % 4;
        m_acc = s;
        if (m_cnt == 255) m_flags[0] = 1'b1;
        else m_cnt = m_cnt + 1;
        if (e == 31 && m == 0) m_flags[1] = 1'b1;
        if (e == 31 && m != 0) m_flags[2] = 1'b1;
        if (l) m_done = 1;
      end
    end else if (ordy) begin
      m_acc = 8'h00; m_cnt = 0; m_done = 0; m_flags = 3'b000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive_a(0, 0, 8'h00, 0, 0);
    bus_b.in_valid  = 1'b0;
    bus_b.in_last   = 1'b0;
    bus_b.sum_in    = 8'h00;
    bus_b.out_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
    check_a("reset", 8'h00, 0, 1'b0, 1'b1, 3'b000);

    // v l  sum  ordy clr | acc cnt ovld irdy flags
    vecs.push_back(mk(1, 0, 8'h3C, 0, 0, 8'h3C, 1, 0, 1, 3'b000));
    vecs.push_back(mk(1, 0, 8'h40, 0, 0, 8'h40, 2, 0, 1, 3'b000));
    vecs.push_back(mk(1, 1, 8'h42, 0, 0, 8'h42, 3, 1, 0, 3'b000));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h42, 3, 1, 0, 3'b000));
    vecs.push_back(mk(1, 1, 8'h55, 0, 0, 8'h42, 3, 1, 0, 3'b000));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h42, 3, 1, 0, 3'b000));
    vecs.push_back(mk(1, 0, 8'h7D, 0, 0, 8'h42, 3, 1, 0, 3'b000));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h42, 3, 1, 0, 3'b000));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 3'b000));
    vecs.push_back(mk(1, 1, 8'hBC, 0, 0, 8'hBC, 1, 1, 0, 3'b000));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 3'b000));
    vecs.push_back(mk(1, 0, 8'h7C, 0, 0, 8'h7C, 1, 0, 1, 3'b010));
    vecs.push_back(mk(1, 1, 8'h7D, 0, 0, 8'h7D, 2, 1, 0, 3'b110));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 8'h00, 0, 0, 1, 3'b000));
    vecs.push_back(mk(1, 0, 8'h3C, 0, 0, 8'h3C, 1, 0, 1, 3'b000));
    vecs.push_back(mk(1, 0, 8'h40, 0, 1, 8'h00, 0, 0, 1, 3'b000));
    vecs.push_back(mk(1, 1, 8'h44, 0, 0, 8'h44, 1, 1, 0, 3'b000));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 1, 3'b000));
    vecs.push_back(mk(0, 1, 8'hFC, 0, 0, 8'h00, 0, 0, 1, 3'b000));
    vecs.push_back(mk(1, 1, 8'hFC, 0, 0, 8'hFC, 1, 1, 0, 3'b010));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 3'b000));

    for (int i = 0; i < vecs.size(); i++) begin
      drive_a(vecs[i].v, vecs[i].l, vecs[i].s, vecs[i].ordy, vecs[i].clr);
      @(posedge clk);
      #1;
      check_a($sformatf("vec%0d", i), vecs[i].e_acc, vecs[i].e_cnt, vecs[i].e_ovld, vecs[i].e_irdy, vecs[i].e_flags);
    end

    // Asynchronous reset in the middle of a stream
    drive_a(1, 0, 8'h3C, 0, 0);
    @(posedge clk); #1;
    drive_a(1, 0, 8'h40, 0, 0);
    @(posedge clk); #1;
    check_a("pre_rst", 8'h40, 2, 1'b0, 1'b1, 3'b000);
    drive_a(0, 0, 8'h00, 0, 0);
    rst_n = 1'b0;
    #1;
    check_a("async_rst", 8'h00, 0, 1'b0, 1'b1, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter saturation on the 2-bit counter instance
    for (int i = 1; i <= 5; i++) begin
      bus_b.in_valid = 1'b1;
      bus_b.in_last  = 1'b0;
      bus_b.sum_in   = 8'h3C;
      @(posedge clk); #1;
      if (i == 3) begin
        chk("sat3 count", bus_b.count, 3);
        chk("sat3 flags", bus_b.flags, 3'b000);
      end
    end
    chk("sat5 count", bus_b.count, 3);
    chk("sat5 flags", bus_b.flags, eff(3'b001));
    chk("sat5 in_ready", bus_b.in_ready, 1'b1);
    bus_b.in_last = 1'b1;
    bus_b.sum_in  = 8'h40;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    bus_b.in_last  = 1'b0;
    chk("sat_done acc", bus_b.acc_out, 8'h40);
    chk("sat_done count", bus_b.count, 3);
    chk("sat_done out_valid", bus_b.out_valid, 1'b1);
    chk("sat_done flags", bus_b.flags, eff(3'b001));
    bus_b.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_b.out_ready = 1'b0;
    chk("sat_ack count", bus_b.count, 0);
    chk("sat_ack flags", bus_b.flags, 3'b000);
    chk("sat_ack out_valid", bus_b.out_valid, 1'b0);

    // Randomized run against the model
    m_acc = 8'h00; m_cnt = 0; m_done = 0; m_flags = 3'b000;
    for (int i = 0; i < 400; i++) begin
      bit       v, l, o, c;
      bit [7:0] s;
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 4) == 0);
      o = $urandom_range(0, 1);
      c = ($urandom_range(0, 24) == 0);
      s = ($urandom_range(0, 7) == 0) ? 8'(8'h7C + $urandom_range(0, 3) + ($urandom_range(0, 1) * 128))
                                      : 8'($urandom);
      drive_a(v, l, s, o, c);
      model_clock(v, l, s, o, c);
      @(posedge clk); #1;
      check_a($sformatf("rnd%0d", i), m_acc, m_cnt, m_done, !m_done, m_flags);
    end
    drive_a(0, 0, 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
